// File: rtl/flptadder_add_normalize_pkg.sv
// Shared definitions for the 10-bit float datapath (5-bit mantissa,
// 5-bit exponent).
// Used by the adder normalise stage, compare_and_shift and the multiplier.
package flptadder_add_normalize_pkg;

    localparam int unsigned FLPT_MW   = 5;
    localparam int unsigned FLPT_EW   = 5;
    localparam int unsigned FLPT_W    = FLPT_MW + FLPT_EW;
    localparam int unsigned FLPT_EMAX = (1 << FLPT_EW) - 1;

    // Adder normalise stage state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } add_state_e;

    // Packed float word as carried between datapath stages
    typedef struct packed {
        logic [FLPT_EW-1:0] exp;
        logic [FLPT_MW-1:0] mant;
    } flpt_t;

endpackage

// File: rtl/flptadder_mant_sum.sv
// Combinational unsigned mantissa add.
// Ports: a, b   - MW-bit aligned mantissas
//        sum_c  - low MW bits of a + b
//        carry_c - carry out of the MW-bit add (sum bit MW)
module flptadder_mant_sum
    import flptadder_add_normalize_pkg::*;
#(
    parameter int unsigned MW = FLPT_MW
) (
    input  logic [MW-1:0] a,
    input  logic [MW-1:0] b,
    output logic [MW-1:0] sum_c,
    output logic          carry_c
);

    assign {carry_c, sum_c} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/flptadder_add_normalize.sv
// Float adder add-and-normalise stage: adds two aligned mantissas at a
// common exponent, then left-shifts one bit per cycle until mantissa bit
// MW-1 is set or the exponent reaches 0. A carry out increments the
// exponent, saturating with ovf at the maximum exponent.
// Ports: clk, rst_n (sync, active low)
//        in_valid/in_ready  + shifted_m1, shifted_m2, new_e  (operands)
//        out_valid/out_ready + out_m, out_e, ovf, zero       (result)
module flptadder_add_normalize
    import flptadder_add_normalize_pkg::*;
#(
    parameter int unsigned MW = FLPT_MW,
    parameter int unsigned EW = FLPT_EW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] shifted_m1,
    input  logic [MW-1:0] shifted_m2,
    input  logic [EW-1:0] new_e,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out_m,
    output logic [EW-1:0] out_e,
    output logic          ovf,
    output logic          zero
);

    localparam logic [EW-1:0] EMAX = {EW{1'b1}};

    add_state_e    state, state_next;
    logic [MW-1:0] m1_r, m1_next;
    logic [MW-1:0] m2_r, m2_next;
    logic [EW-1:0] e_r, e_next;
    logic [MW-1:0] mant_r, mant_next;
    logic [EW-1:0] exp_r, exp_next;
    logic          ovf_r, ovf_next;
    logic          zero_r, zero_next;
    logic          in_ready_r, in_ready_next;
    logic          out_valid_r, out_valid_next;

    logic [MW-1:0] sum_c;
    logic          carry_c;

    flptadder_mant_sum #(.MW(MW)) u_mant_sum (
        .a       (m1_r),
        .b       (m2_r),
        .sum_c   (sum_c),
        .carry_c (carry_c)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            m1_r        <= '0;
            m2_r        <= '0;
            e_r         <= '0;
            mant_r      <= '0;
            exp_r       <= '0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state       <= state_next;
            m1_r        <= m1_next;
            m2_r        <= m2_next;
            e_r         <= e_next;
            mant_r      <= mant_next;
            exp_r       <= exp_next;
            ovf_r       <= ovf_next;
            zero_r      <= zero_next;
            in_ready_r  <= in_ready_next;
            out_valid_r <= out_valid_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        m1_next    = m1_r;
        m2_next    = m2_r;
        e_next     = e_r;
        mant_next  = mant_r;
        exp_next   = exp_r;
        ovf_next   = ovf_r;
        zero_next  = zero_r;

        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    m1_next    = shifted_m1;
                    m2_next    = shifted_m2;
                    e_next     = new_e;
                    state_next = ST_ADD;
                end
            end
            ST_ADD: begin
                ovf_next   = 1'b0;
                zero_next  = 1'b0;
                exp_next   = e_r;
                mant_next  = sum_c;
                state_next = ST_DONE;
                if (carry_c) begin
                    if (e_r != EMAX) begin
                        // drop the LSB, carry becomes the leading one
                        mant_next = {carry_c, sum_c[MW-1:1]};
                        exp_next  = e_r + EW'(1);
                    end else begin
                        mant_next = '1;
                        ovf_next  = 1'b1;
                    end
                end else if (sum_c == '0) begin
                    exp_next  = '0;
                    zero_next = 1'b1;
                end else if (!sum_c[MW-1] && (e_r != '0)) begin
                    state_next = ST_NORM;
                end
            end
            ST_NORM: begin
                // exp_r is nonzero here, so the decrement never wraps
                mant_next = {mant_r[MW-2:0], 1'b0};
                exp_next  = exp_r - EW'(1);
                if (mant_r[MW-2] || (exp_r == EW'(1))) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        in_ready_next  = (state_next == ST_IDLE);
        out_valid_next = (state_next == ST_DONE);
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_m     = mant_r;
    assign out_e     = exp_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule
